// File: rtl/seg7_scan.sv
// Multiplexed common-anode seven-segment driver with per-frame BCD snapshot and leading-zero blanking.
// Optional blinking is enabled by defining SEG7_BLINK_EN (adds the blink input and a frame counter).
module seg7_scan #(
    parameter int NDIG        = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_BIT   = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4*NDIG-1:0] bcd,
    input  logic [NDIG-1:0]   dp,
    input  logic              lzb,
`ifdef SEG7_BLINK_EN
    input  logic              blink,
`endif
    output logic [NDIG-1:0]   an,
    output logic [6:0]        seg,
    output logic              dp_n
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = $clog2(NDIG);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NDIG - 1);

    if (NDIG < 2 || NDIG > 8) begin : g_bad_ndig
        $error("seg7_scan: NDIG must be 2..8");
    end
    if (REFRESH_DIV < 2) begin : g_bad_div
        $error("seg7_scan: REFRESH_DIV must be >= 2");
    end
    if (BLINK_BIT < 0) begin : g_bad_blink
        $error("seg7_scan: BLINK_BIT must be >= 0");
    end

    logic [CNT_W-1:0]  cnt;
    logic [IDX_W-1:0]  idx;
    logic [4*NDIG-1:0] snap_bcd;
    logic [NDIG-1:0]   snap_dp;
    logic              tick;
    logic              frame_end;
    logic              dark;

    logic [NDIG-1:0]   blank_vec;
    logic              zrun;
    logic [3:0]        cur_dig;
    logic              cur_dp;
    logic              cur_blank;
    logic [NDIG-1:0]   an_nxt;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h3F;
        endcase
        return s;
    endfunction

    assign tick      = (cnt == CNT_MAX);
    assign frame_end = tick && (idx == IDX_MAX);

    // Scan control: prescaler, digit index and frame snapshot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            idx      <= '0;
            snap_bcd <= '0;
            snap_dp  <= '0;
        end else begin
            if (tick) begin
                cnt <= '0;
                idx <= frame_end ? '0 : idx + IDX_W'(1);
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
            if (frame_end) begin
                snap_bcd <= bcd;
                snap_dp  <= dp;
            end
        end
    end

`ifdef SEG7_BLINK_EN
    logic [BLINK_BIT:0] frame_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt <= '0;
        end else if (frame_end) begin
            frame_cnt <= frame_cnt + (BLINK_BIT+1)'(1);
        end
    end

    assign dark = blink & frame_cnt[BLINK_BIT];
`else
    assign dark = 1'b0;
`endif

    // Digit select and blanking from the snapshot; lzb acts live
    always_comb begin
        zrun      = lzb;
        blank_vec = '0;
        for (int k = NDIG - 1; k >= 1; k--) begin
            zrun         = zrun & (snap_bcd[4*k +: 4] == 4'd0);
            blank_vec[k] = zrun;
        end
        cur_dig   = '0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        an_nxt    = '1;
        for (int k = 0; k < NDIG; k++) begin
            if (idx == IDX_W'(k)) begin
                cur_dig   = snap_bcd[4*k +: 4];
                cur_dp    = snap_dp[k];
                cur_blank = blank_vec[k];
                an_nxt[k] = 1'b0;
            end
        end
        if (cur_blank || dark) begin
            an_nxt = '1;
        end
    end

    // Registered pin drivers, one clock behind idx
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an   <= '1;
            seg  <= 7'h7F;
            dp_n <= 1'b1;
        end else begin
            an   <= an_nxt;
            seg  <= seg_decode(cur_dig);
            dp_n <= ~cur_dp | cur_blank | dark;
        end
    end

endmodule

// File: tb/tb_seg7_scan.sv
// Scoreboarded bench for seg7_scan (NDIG=4, REFRESH_DIV=4): a reference model pushes the
// expected pins at every clock, which are popped and compared on the following falling edge.
module tb_seg7_scan;

    localparam int NDIG  = 4;
    localparam int DIV   = 4;
    localparam int FRAME = NDIG * DIV;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] bcd;
    logic [3:0]  dp;
    logic        lzb;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp_n;
`ifdef SEG7_BLINK_EN
    logic        blink = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    seg7_scan #(.NDIG(NDIG), .REFRESH_DIV(DIV), .BLINK_BIT(1)) dut (
        .clk  (clk),
        .rst  (rst),
        .bcd  (bcd),
        .dp   (dp),
        .lzb  (lzb),
`ifdef SEG7_BLINK_EN
        .blink(blink),
`endif
        .an   (an),
        .seg  (seg),
        .dp_n (dp_n)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] ref_seg(input logic [3:0] d);
        case (d)
            4'd0: return 7'h40;
            4'd1: return 7'h79;
            4'd2: return 7'h24;
            4'd3: return 7'h30;
            4'd4: return 7'h19;
            4'd5: return 7'h12;
            4'd6: return 7'h02;
            4'd7: return 7'h78;
            4'd8: return 7'h00;
            4'd9: return 7'h10;
            default: return 7'h3F;
        endcase
    endfunction

    function automatic logic [11:0] model_out(input logic [1:0] i, input logic [15:0] sb,
                                              input logic [3:0] sd, input logic lz);
        logic       blank;
        logic [3:0] a;
        logic [3:0] d;
        d     = sb[4*i +: 4];
        blank = lz && (i != 2'd0) && ((sb >> (4*i)) == 16'd0);
        a     = blank ? 4'b1111 : ~(4'b0001 << i);
        return {a, ref_seg(d), blank ? 1'b1 : ~sd[i]};
    endfunction

    logic [1:0]  m_cnt;
    logic [1:0]  m_idx;
    logic [15:0] m_sb;
    logic [3:0]  m_sd;
    logic [11:0] exp_q[$];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt <= '0;
            m_idx <= '0;
            m_sb  <= '0;
            m_sd  <= '0;
            exp_q.delete();
        end else begin
            exp_q.push_back(model_out(m_idx, m_sb, m_sd, lzb));
            m_cnt <= (m_cnt == 2'(DIV - 1)) ? 2'd0 : m_cnt + 2'd1;
            if (m_cnt == 2'(DIV - 1)) begin
                m_idx <= m_idx + 2'd1;
                if (m_idx == 2'(NDIG - 1)) begin
                    m_sb <= bcd;
                    m_sd <= dp;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && exp_q.size() > 0) begin
            check("scan", {20'd0, an, seg, dp_n}, {20'd0, exp_q.pop_front()});
        end
    end

    task automatic wait_frames(input int n);
        repeat (n * FRAME) @(negedge clk);
    endtask

    task automatic wait_an(input string tag, input logic [3:0] target,
                           input logic [6:0] seg_exp, input logic dpn_exp);
        bit found = 0;
        for (int c = 0; c < 4 * FRAME && !found; c++) begin
            @(negedge clk);
            if (an === target) found = 1;
        end
        check({tag, "_seen"}, found, 1);
        if (found) begin
            check({tag, "_seg"}, seg, seg_exp);
            check({tag, "_dpn"}, dp_n, dpn_exp);
        end
    endtask

    task automatic first_lit(input string tag);
        bit found = 0;
        for (int c = 0; c < 4 * FRAME && !found; c++) begin
            @(negedge clk);
            if (an !== 4'b1111) found = 1;
        end
        check({tag, "_seen"}, found, 1);
        check({tag, "_an"}, an, 4'b1110);
        check({tag, "_seg"}, seg, 7'h40);
    endtask

    task automatic count_lit(input string tag, input logic [3:0] forbidden_mask);
        int bad = 0;
        repeat (FRAME) begin
            @(negedge clk);
            if ((~an & forbidden_mask) != 4'b0000) bad++;
        end
        check(tag, bad, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bcd = 16'h0000;
        dp  = 4'b0000;
        lzb = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_an", an, 4'b1111);
        check("rst_seg", seg, 7'h7F);
        check("rst_dpn", dp_n, 1'b1);
        rst = 1'b0;
        first_lit("boot");

        bcd = 16'h1234;
        wait_frames(2);
        wait_an("scan_d0", 4'b1110, 7'h19, 1'b1);
        wait_an("scan_d1", 4'b1101, 7'h30, 1'b1);
        wait_an("scan_d2", 4'b1011, 7'h24, 1'b1);
        wait_an("scan_d3", 4'b0111, 7'h79, 1'b1);

        wait_an("snap_d0", 4'b1110, 7'h19, 1'b1);
        wait_an("snap_d1", 4'b1101, 7'h30, 1'b1);
        bcd = 16'h5678;
        wait_an("snap_old2", 4'b1011, 7'h24, 1'b1);
        wait_an("snap_old3", 4'b0111, 7'h79, 1'b1);
        wait_an("snap_new0", 4'b1110, 7'h00, 1'b1);
        wait_an("snap_new1", 4'b1101, 7'h78, 1'b1);
        wait_an("snap_new2", 4'b1011, 7'h02, 1'b1);
        wait_an("snap_new3", 4'b0111, 7'h12, 1'b1);

        lzb = 1'b1;
        bcd = 16'h0007;
        wait_frames(2);
        count_lit("lzb7_dark", 4'b1110);
        wait_an("lzb7_d0", 4'b1110, 7'h78, 1'b1);
        bcd = 16'h0000;
        wait_frames(2);
        count_lit("lzb0_dark", 4'b1110);
        wait_an("lzb0_d0", 4'b1110, 7'h40, 1'b1);
        bcd = 16'h0105;
        wait_frames(2);
        count_lit("lzb105_dark", 4'b1000);
        wait_an("lzb105_d2", 4'b1011, 7'h79, 1'b1);
        wait_an("lzb105_d1", 4'b1101, 7'h40, 1'b1);
        wait_an("lzb105_d0", 4'b1110, 7'h12, 1'b1);

        lzb = 1'b0;
        bcd = 16'h00A0;
        dp  = 4'b0010;
        wait_frames(2);
        wait_an("inv_d1", 4'b1101, 7'h3F, 1'b0);
        wait_an("inv_d3", 4'b0111, 7'h40, 1'b1);
        wait_an("inv_d0", 4'b1110, 7'h40, 1'b1);

        wait_an("mid_d2", 4'b1011, 7'h40, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("async_an", an, 4'b1111);
        check("async_seg", seg, 7'h7F);
        check("async_dpn", dp_n, 1'b1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        first_lit("restart");
        wait_frames(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
